// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, address generation and branch resolution, with a
// bit-serial shifter. Define FAST_SHIFT_EN to use a single-cycle barrel shifter instead.

`ifndef EX_NOP
`define EX_NOP   32'd0
`define EX_ADD   32'd1
`define EX_SUB   32'd2
`define EX_SLL   32'd3
`define EX_SLT   32'd4
`define EX_SLTU  32'd5
`define EX_XOR   32'd6
`define EX_SRL   32'd7
`define EX_SRA   32'd8
`define EX_OR    32'd9
`define EX_AND   32'd10
`define EX_ADDI  32'd11
`define EX_SLTI  32'd12
`define EX_SLTIU 32'd13
`define EX_XORI  32'd14
`define EX_ORI   32'd15
`define EX_ANDI  32'd16
`define EX_SLLI  32'd17
`define EX_SRLI  32'd18
`define EX_SRAI  32'd19
`define EX_LUI   32'd20
`define EX_AUIPC 32'd21
`define EX_JAL   32'd22
`define EX_JALR  32'd23
`define EX_BEQ   32'd24
`define EX_BNE   32'd25
`define EX_BLT   32'd26
`define EX_BGE   32'd27
`define EX_BLTU  32'd28
`define EX_BGEU  32'd29
`define EX_LB    32'd30
`define EX_LH    32'd31
`define EX_LW    32'd32
`define EX_LBU   32'd33
`define EX_LHU   32'd34
`define EX_SB    32'd35
`define EX_SH    32'd36
`define EX_SW    32'd37
`endif

module ex_stage #(
    parameter int XLEN        = 32,
    parameter int OP_W        = 32,
    parameter int LOG_REG_CNT = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   start,
    input  logic [OP_W-1:0]        ex_op,
    input  logic [XLEN-1:0]        rs1_val,
    input  logic [XLEN-1:0]        rs2_val,
    input  logic [LOG_REG_CNT-1:0] rd_id,
    input  logic [XLEN-1:0]        imm,
    input  logic [XLEN-1:0]        pc_val,
    output logic                   ex_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_W-1:0]        out_op,
    output logic [XLEN-1:0]        out_result,
    output logic [XLEN-1:0]        out_store_val,
    output logic [LOG_REG_CNT-1:0] out_rd_id,
    output logic                   br_taken,
    output logic [XLEN-1:0]        br_target
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifndef FAST_SHIFT_EN
        S_SHIFT = 2'd1,
`endif
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    state_t                 r_state;
    logic [OP_W-1:0]        r_op;
    logic [XLEN-1:0]        r_result;
    logic [XLEN-1:0]        r_store_val;
    logic [LOG_REG_CNT-1:0] r_rd_id;
    logic                   r_br_taken;
    logic [XLEN-1:0]        r_br_target;
    logic                   r_valid;
    logic                   r_done;
`ifndef FAST_SHIFT_EN
    logic [4:0]             r_shamt;
    logic [XLEN-1:0]        r_shift_val;
    logic [1:0]             r_shift_kind;
    logic [XLEN-1:0]        w_step;
`endif

    logic            w_is_imm;
    logic [XLEN-1:0] w_op2;
    logic            w_lt;
    logic            w_ltu;
    logic [XLEN-1:0] w_jsum;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_shift_res;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_store_val;
    logic            w_taken;
    logic            w_is_shift;
    logic [1:0]      w_shift_kind;
    logic [4:0]      w_shamt;

    always_comb begin
        w_is_imm = 1'b0;
        case (ex_op)
            `EX_ADDI, `EX_SLTI, `EX_SLTIU, `EX_XORI, `EX_ORI, `EX_ANDI,
            `EX_SLLI, `EX_SRLI, `EX_SRAI: w_is_imm = 1'b1;
            default:                       w_is_imm = 1'b0;
        endcase
    end

    assign w_op2   = w_is_imm ? imm : rs2_val;
    assign w_lt    = $signed(rs1_val) < $signed(w_op2);
    assign w_ltu   = rs1_val < w_op2;
    assign w_jsum  = rs1_val + imm;
    assign w_shamt = w_op2[4:0];

    always_comb begin
        w_result     = '0;
        w_target     = '0;
        w_taken      = 1'b0;
        w_store_val  = '0;
        w_is_shift   = 1'b0;
        w_shift_kind = SH_SLL;
        case (ex_op)
            `EX_ADD, `EX_ADDI:   w_result = rs1_val + w_op2;
            `EX_SUB:             w_result = rs1_val - rs2_val;
            `EX_SLT, `EX_SLTI:   w_result = {{(XLEN-1){1'b0}}, w_lt};
            `EX_SLTU, `EX_SLTIU: w_result = {{(XLEN-1){1'b0}}, w_ltu};
            `EX_XOR, `EX_XORI:   w_result = rs1_val ^ w_op2;
            `EX_OR, `EX_ORI:     w_result = rs1_val | w_op2;
            `EX_AND, `EX_ANDI:   w_result = rs1_val & w_op2;
            `EX_SLL, `EX_SLLI: begin
                w_is_shift   = 1'b1;
                w_shift_kind = SH_SLL;
            end
            `EX_SRL, `EX_SRLI: begin
                w_is_shift   = 1'b1;
                w_shift_kind = SH_SRL;
            end
            `EX_SRA, `EX_SRAI: begin
                w_is_shift   = 1'b1;
                w_shift_kind = SH_SRA;
            end
            `EX_LUI:   w_result = imm;
            `EX_AUIPC: w_result = pc_val + imm;
            `EX_JAL: begin
                w_result = pc_val + XLEN'(4);
                w_target = pc_val + imm;
                w_taken  = 1'b1;
            end
            `EX_JALR: begin
                w_result = pc_val + XLEN'(4);
                w_target = {w_jsum[XLEN-1:1], 1'b0};
                w_taken  = 1'b1;
            end
            `EX_BEQ: begin
                w_target = pc_val + imm;
                w_taken  = (rs1_val == rs2_val);
            end
            `EX_BNE: begin
                w_target = pc_val + imm;
                w_taken  = (rs1_val != rs2_val);
            end
            `EX_BLT: begin
                w_target = pc_val + imm;
                w_taken  = w_lt;
            end
            `EX_BGE: begin
                w_target = pc_val + imm;
                w_taken  = !w_lt;
            end
            `EX_BLTU: begin
                w_target = pc_val + imm;
                w_taken  = w_ltu;
            end
            `EX_BGEU: begin
                w_target = pc_val + imm;
                w_taken  = !w_ltu;
            end
            `EX_LB, `EX_LH, `EX_LW, `EX_LBU, `EX_LHU: w_result = w_jsum;
            `EX_SB, `EX_SH, `EX_SW: begin
                w_result    = w_jsum;
                w_store_val = rs2_val;
            end
            default: w_result = '0;
        endcase
        if (w_is_shift) begin
            w_result = w_shift_res;
        end
    end

`ifdef FAST_SHIFT_EN
    always_comb begin
        case (w_shift_kind)
            SH_SLL:  w_shift_res = rs1_val << w_shamt;
            SH_SRL:  w_shift_res = rs1_val >> w_shamt;
            default: w_shift_res = $unsigned($signed(rs1_val) >>> w_shamt);
        endcase
    end
`else
    // Only a zero shift amount completes straight from IDLE; it passes rs1 through.
    assign w_shift_res = rs1_val;

    always_comb begin
        case (r_shift_kind)
            SH_SLL:  w_step = {r_shift_val[XLEN-2:0], 1'b0};
            SH_SRL:  w_step = {1'b0, r_shift_val[XLEN-1:1]};
            default: w_step = {r_shift_val[XLEN-1], r_shift_val[XLEN-1:1]};
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_op        <= `EX_NOP;
            r_result    <= '0;
            r_store_val <= '0;
            r_rd_id     <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
`ifndef FAST_SHIFT_EN
            r_shamt      <= '0;
            r_shift_val  <= '0;
            r_shift_kind <= SH_SLL;
`endif
        end else if (rdy) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && ex_op != `EX_NOP) begin
                        r_op        <= ex_op;
                        r_rd_id     <= rd_id;
                        r_store_val <= w_store_val;
                        r_br_taken  <= w_taken;
                        r_br_target <= w_target;
`ifndef FAST_SHIFT_EN
                        if (w_is_shift && w_shamt != 5'd0) begin
                            r_shift_val  <= rs1_val;
                            r_shamt      <= w_shamt;
                            r_shift_kind <= w_shift_kind;
                            r_state      <= S_SHIFT;
                        end else
`endif
                        begin
                            r_result <= w_result;
                            r_valid  <= 1'b1;
                            r_state  <= S_HOLD;
                        end
                    end
                end
`ifndef FAST_SHIFT_EN
                // The last step is written straight to the result so that latency is shamt+1.
                S_SHIFT: begin
                    r_shift_val <= w_step;
                    r_shamt     <= r_shamt - 5'd1;
                    if (r_shamt == 5'd1) begin
                        r_result <= w_step;
                        r_valid  <= 1'b1;
                        r_state  <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_op    <= `EX_NOP;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ex_done       = r_done;
    assign out_valid     = r_valid;
    assign out_op        = r_op;
    assign out_result    = r_result;
    assign out_store_val = r_store_val;
    assign out_rd_id     = r_rd_id;
    assign br_taken      = r_br_taken;
    assign br_target     = r_br_target;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expected latencies follow FAST_SHIFT_EN when defined.

module tb_ex_stage;

    localparam logic [31:0] OP_NOP   = 32'd0;
    localparam logic [31:0] OP_ADD   = 32'd1;
    localparam logic [31:0] OP_SUB   = 32'd2;
    localparam logic [31:0] OP_SLL   = 32'd3;
    localparam logic [31:0] OP_SLT   = 32'd4;
    localparam logic [31:0] OP_SLTU  = 32'd5;
    localparam logic [31:0] OP_SRL   = 32'd7;
    localparam logic [31:0] OP_SRA   = 32'd8;
    localparam logic [31:0] OP_SLLI  = 32'd17;
    localparam logic [31:0] OP_SRLI  = 32'd18;
    localparam logic [31:0] OP_SRAI  = 32'd19;
    localparam logic [31:0] OP_LUI   = 32'd20;
    localparam logic [31:0] OP_AUIPC = 32'd21;
    localparam logic [31:0] OP_JAL   = 32'd22;
    localparam logic [31:0] OP_JALR  = 32'd23;
    localparam logic [31:0] OP_BLT   = 32'd26;
    localparam logic [31:0] OP_BLTU  = 32'd28;
    localparam logic [31:0] OP_SW    = 32'd37;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        start;
    logic [31:0] ex_op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_id;
    logic [31:0] imm;
    logic [31:0] pc_val;
    logic        ex_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op;
    logic [31:0] out_result;
    logic [31:0] out_store_val;
    logic [4:0]  out_rd_id;
    logic        br_taken;
    logic [31:0] br_target;

    int total = 0;
    int bad   = 0;

    ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .start        (start),
        .ex_op        (ex_op),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rd_id        (rd_id),
        .imm          (imm),
        .pc_val       (pc_val),
        .ex_done      (ex_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_result   (out_result),
        .out_store_val(out_store_val),
        .out_rd_id    (out_rd_id),
        .br_taken     (br_taken),
        .br_target    (br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int shLat(input int s);
`ifdef FAST_SHIFT_EN
        return 1;
`else
        return s + 1;
`endif
    endfunction

    // A new op is only offered when the stage has nothing in flight.
    task automatic applyStimulus(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] pc, input logic [4:0] rd);
        checkOutput("idle_before_start", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        ex_op   = op;
        rs1_val = a;
        rs2_val = b;
        imm     = im;
        pc_val  = pc;
        rd_id   = rd;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        ex_op   = OP_NOP;
    endtask

    task automatic waitValid(output int n);
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic [31:0] pc,
                         input int expLat, input logic [31:0] expRes);
        int n;
        applyStimulus(op, a, b, im, pc, 5'd3);
        waitValid(n);
        checkOutput({tag, "_latency"}, n, expLat);
        checkOutput({tag, "_result"}, out_result, expRes);
    endtask

    task automatic expectDone(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done"}, {31'd0, ex_done}, 32'd1);
        checkOutput({tag, "_valid_clr"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_op_clr"}, out_op, OP_NOP);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, {31'd0, ex_done}, 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b0; rdy = 1'b1; start = 1'b0; out_ready = 1'b1;
        ex_op = OP_NOP; rs1_val = '0; rs2_val = '0; imm = '0; pc_val = '0; rd_id = '0;
        #12;
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_op", out_op, OP_NOP);
        checkOutput("rst_result", out_result, 32'd0);
        checkOutput("rst_done", {31'd0, ex_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd7);
        checkOutput("add_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("add_result", out_result, 32'h8000_0000);
        checkOutput("add_op", out_op, OP_ADD);
        checkOutput("add_rd", {27'd0, out_rd_id}, 32'd7);
        checkOutput("add_taken", {31'd0, br_taken}, 32'd0);
        checkOutput("add_early_done", {31'd0, ex_done}, 32'd0);
        expectDone("add");

        runOp("sub", OP_SUB, 32'd5, 32'd7, 32'd0, 32'd0, 1, 32'hFFFF_FFFE);
        expectDone("sub");
        runOp("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1, 32'd1);
        expectDone("slt");
        runOp("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1, 32'd0);
        expectDone("sltu");
        runOp("lui", OP_LUI, 32'd0, 32'd0, 32'hABCD_E000, 32'd0, 1, 32'hABCD_E000);
        expectDone("lui");
        runOp("auipc", OP_AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 1, 32'h3000);
        expectDone("auipc");

        runOp("slli", OP_SLLI, 32'd1, 32'd0, 32'd3, 32'd0, shLat(3), 32'd8);
        expectDone("slli");
        runOp("srl", OP_SRL, 32'hF000_0000, 32'd4, 32'd0, 32'd0, shLat(4), 32'h0F00_0000);
        expectDone("srl");
        runOp("sra1", OP_SRA, 32'h8000_0000, 32'd1, 32'd0, 32'd0, shLat(1), 32'hC000_0000);
        expectDone("sra1");
        runOp("srai31", OP_SRAI, 32'h8000_0000, 32'd0, 32'd31, 32'd0, shLat(31), 32'hFFFF_FFFF);
        expectDone("srai31");
        runOp("sll0", OP_SLL, 32'h1234_5678, 32'h20, 32'd0, 32'd0, 1, 32'h1234_5678);
        expectDone("sll0");

        runOp("blt", OP_BLT, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 32'h100, 1, 32'd0);
        checkOutput("blt_taken", {31'd0, br_taken}, 32'd1);
        checkOutput("blt_target", br_target, 32'hF8);
        expectDone("blt");
        runOp("bltu", OP_BLTU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 32'h100, 1, 32'd0);
        checkOutput("bltu_taken", {31'd0, br_taken}, 32'd0);
        checkOutput("bltu_target", br_target, 32'hF8);
        expectDone("bltu");
        runOp("jalr", OP_JALR, 32'h1001, 32'd0, 32'd2, 32'h40, 1, 32'h44);
        checkOutput("jalr_taken", {31'd0, br_taken}, 32'd1);
        checkOutput("jalr_target", br_target, 32'h1002);
        expectDone("jalr");
        runOp("jal", OP_JAL, 32'd0, 32'd0, 32'h10, 32'h200, 1, 32'h204);
        checkOutput("jal_target", br_target, 32'h210);
        expectDone("jal");
        runOp("sw", OP_SW, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'd0, 1, 32'hFFC);
        checkOutput("sw_store", out_store_val, 32'hDEAD_BEEF);
        checkOutput("sw_taken", {31'd0, br_taken}, 32'd0);
        expectDone("sw");

        out_ready = 1'b0;
        runOp("bp", OP_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 1, 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_result", out_result, 32'd7);
            checkOutput("bp_done", {31'd0, ex_done}, 32'd0);
        end
        out_ready = 1'b1;
        expectDone("bp");

        // Three frozen edges in the middle of an 8-bit shift.
        applyStimulus(OP_SRLI, 32'h8000_0000, 32'd0, 32'd8, 32'd0, 5'd1);
        n = 1;
        while (out_valid !== 1'b1 && n < 200) begin
            if (n == 3) rdy = 1'b0;
            if (n == 6) rdy = 1'b1;
            @(negedge clk);
            n++;
        end
        rdy = 1'b1;
`ifdef FAST_SHIFT_EN
        checkOutput("stall_latency", n, 32'd1);
`else
        checkOutput("stall_latency", n, 32'd12);
`endif
        checkOutput("stall_result", out_result, 32'h0080_0000);
        expectDone("stall");

        applyStimulus(OP_SLL, 32'd1, 32'd20, 32'd0, 32'd0, 5'd2);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_done", {31'd0, ex_done}, 32'd0);
        checkOutput("abort_op", out_op, OP_NOP);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || ex_done !== 1'b0) seen = 1'b1;
        end
        checkOutput("abort_no_retire", {31'd0, seen}, 32'd0);
        runOp("post_rst", OP_ADD, 32'd10, 32'd20, 32'd0, 32'd0, 1, 32'd30);
        expectDone("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
